// File: rtl/rs_fec_pkg.sv
// ---------------------------------------------------------------------------
// rs_fec_pkg: RS(544,514) GF(2^10) constants, types and field arithmetic
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rs_fec_pkg;

  localparam int N_SYM = 544;
  localparam int K_SYM = 514;
  localparam int SYM_W = 10;
  localparam int N_PAR = 30;
  localparam logic [10:0] PRIM_POLY = 11'h409;

  typedef logic [SYM_W-1:0] rs_sym_t;
  typedef logic [N_PAR-1:0][SYM_W-1:0] rs_par_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  function automatic rs_sym_t gf_mul(input rs_sym_t a, input rs_sym_t b);
    logic [2*SYM_W-2:0] prod;
    prod = '0;
    for (int i = 0; i < SYM_W; i++)
      if (b[i]) prod ^= ({{(SYM_W-1){1'b0}}, a} << i);
    // Fold the high-order product bits back down, top bit first.
    for (int k = 2*SYM_W-2; k >= SYM_W; k--)
      if (prod[k]) prod ^= ({{(SYM_W-2){1'b0}}, PRIM_POLY} << (k-SYM_W));
    return prod[SYM_W-1:0];
  endfunction

  // g(x) = prod_{j=0..29} (x + alpha^j); returns the 30 non-leading coefficients.
  function automatic rs_par_t gen_poly();
    rs_sym_t g [0:N_PAR];
    rs_sym_t root;
    rs_par_t res;
    g[0] = 10'd1;
    for (int i = 1; i <= N_PAR; i++) g[i] = 10'd0;
    root = 10'd1;
    for (int j = 0; j < N_PAR; j++) begin
      for (int i = j+1; i > 0; i--) g[i] = g[i-1] ^ gf_mul(g[i], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 10'd2);
    end
    for (int i = 0; i < N_PAR; i++) res[i] = g[i];
    return res;
  endfunction

  localparam rs_par_t RS_GEN = gen_poly();

endpackage

`default_nettype wire

// File: rtl/rs_lfsr_step.sv
// ---------------------------------------------------------------------------
// rs_lfsr_step: one combinational symbol step of the RS parity LFSR
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rs_lfsr_step
  import rs_fec_pkg::*;
(
  input  rs_sym_t sym,
  input  rs_par_t r_in,
  output rs_par_t r_out
);

  rs_sym_t fb;

  always_comb begin
    fb       = sym ^ r_in[N_PAR-1];
    r_out[0] = gf_mul(fb, RS_GEN[0]);
    for (int i = 1; i < N_PAR; i++)
      r_out[i] = r_in[i-1] ^ gf_mul(fb, RS_GEN[i]);
  end

endmodule

`default_nettype wire

// File: rtl/rs_parity_encoder.sv
// ---------------------------------------------------------------------------
// rs_parity_encoder: iterative RS(544,514) parity generator, one codeword lane
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rs_parity_encoder
  import rs_fec_pkg::*;
#(
  parameter int N_SYM          = rs_fec_pkg::N_SYM,
  parameter int K_SYM          = rs_fec_pkg::K_SYM,
  parameter int SYM_W          = rs_fec_pkg::SYM_W,
  parameter int SYMS_PER_CYCLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_SYM*SYM_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_SYM*SYM_W-1:0] out_data
);

  localparam int MSG_W = K_SYM*SYM_W;
  localparam int CW_W  = N_SYM*SYM_W;
  localparam int PAR_W = (N_SYM-K_SYM)*SYM_W;
  localparam int STEPS = K_SYM/SYMS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS-1);

  if (SYMS_PER_CYCLE != 1 && SYMS_PER_CYCLE != 2) begin : g_bad_spc
    $error("SYMS_PER_CYCLE must be 1 or 2");
  end

  enc_state_t       state;
  logic [MSG_W-1:0] msg_sr;
  rs_par_t          r;
  logic [CNT_W-1:0] cnt;
  rs_par_t          r_chain [0:SYMS_PER_CYCLE];

  // The incoming parity field is don't-care and is never looked at.
  logic unused_par_field;
  assign unused_par_field = ^in_data[PAR_W-1:0];

  assign r_chain[0] = r;

  for (genvar k = 0; k < SYMS_PER_CYCLE; k++) begin : g_step
    rs_lfsr_step u_step (
      .sym   (msg_sr[MSG_W-1-k*SYM_W -: SYM_W]),
      .r_in  (r_chain[k]),
      .r_out (r_chain[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      msg_sr    <= '0;
      r         <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            // out_data doubles as the held message field for the whole encode.
            msg_sr   <= in_data[CW_W-1 -: MSG_W];
            out_data <= {in_data[CW_W-1 -: MSG_W], {PAR_W{1'b0}}};
            r        <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_ENC;
          end
        end
        ST_ENC: begin
          r      <= r_chain[SYMS_PER_CYCLE];
          msg_sr <= msg_sr << (SYMS_PER_CYCLE*SYM_W);
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            out_data[PAR_W-1:0] <= r_chain[SYMS_PER_CYCLE];
            out_valid           <= 1'b1;
            state               <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
